// File: rtl/sprite_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_dma_if
//  Description : Bundles the MMIO, main-memory read and sprite-RAM write
//                signals of the sprite-table DMA controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_dma_if;
  logic [15:0] adr;
  logic        memwrite;
  logic [15:0] writedata;
  logic [15:0] memdata;
  logic        vbright;
  logic        bus_req;
  logic        bus_grant;
  logic [15:0] rd_adr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_adr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done_irq;

  // DMA controller side
  modport slave (
    input  adr, memwrite, writedata, vbright, bus_grant, rd_data,
    output memdata, bus_req, rd_adr, rd_en, wr_en, wr_adr, wr_data, busy, done_irq
  );

  // Processor / arbiter / memory side
  modport master (
    output adr, memwrite, writedata, vbright, bus_grant, rd_data,
    input  memdata, bus_req, rd_adr, rd_en, wr_en, wr_adr, wr_data, busy, done_irq
  );
endinterface
`default_nettype wire

// File: rtl/sprite_dma.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_dma
//  Description : Copies a block of words from main memory into sprite RAM at
//                the start of vertical blank. Reads are issued only while the
//                arbiter grants the bus; each read is written one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_dma #(
  parameter logic [15:0] SRC_REG     = 16'h4383,
  parameter logic [15:0] LEN_REG     = 16'h4384,
  parameter logic [15:0] CTRL_REG    = 16'h4385,
  parameter logic [15:0] SPRITE_BASE = 16'h4000,
  parameter int unsigned MAX_LEN     = 512
) (
  input  logic        clk,
  input  logic        rst,
  sprite_dma_if.slave bus
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_REQ   = 3'd2,
    S_COPY  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q;
  logic [9:0]  len_q;
  logic [15:0] src_ptr_q, src_ptr_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [9:0]  dst_off_q, dst_off_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        done_irq_q, done_irq_d;
  logic        vbright_q;
  logic        wr_en_q;
  logic [15:0] memdata_q;

  logic ctrl_wr, ctrl_rd, start_req, abort_req;
  logic vb_fall, vb_rise, rd_fire, busy_w;

  assign ctrl_wr   = bus.memwrite && (bus.adr == CTRL_REG);
  assign ctrl_rd   = !bus.memwrite && (bus.adr == CTRL_REG);
  assign start_req = ctrl_wr && bus.writedata[0];
  assign abort_req = ctrl_wr && bus.writedata[1];
  assign vb_fall   = vbright_q && !bus.vbright;
  assign vb_rise   = !vbright_q && bus.vbright;
  assign busy_w    = (state_q != S_IDLE);

  // A read is withheld in the cycle an abort or overrun is seen so that only
  // already-issued reads produce writes.
  assign rd_fire = rst && (state_q == S_COPY) && bus.bus_grant && !vb_rise && !abort_req;

  // Next-state and datapath update for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    remaining_d = remaining_q;
    dst_off_d   = dst_off_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    done_irq_d  = 1'b0;

    if (ctrl_rd) begin
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end
    if (wr_en_q) begin
      dst_off_d = dst_off_q + 10'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req && !abort_req) begin
          src_ptr_d   = src_q;
          remaining_d = len_q;
          dst_off_d   = 10'd0;
          overrun_d   = 1'b0;
          if (len_q == 10'd0) begin
            done_d     = 1'b1;
            done_irq_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (abort_req)    state_d = S_IDLE;
        else if (vb_fall) state_d = S_REQ;
      end
      S_REQ: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (vb_rise) begin
          state_d   = S_IDLE;
          overrun_d = 1'b1;
        end else if (bus.bus_grant) begin
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (vb_rise) begin
          state_d   = S_IDLE;
          overrun_d = 1'b1;
        end else if (rd_fire) begin
          src_ptr_d   = src_ptr_q + 16'd1;
          remaining_d = remaining_q - 10'd1;
          if (remaining_q == 10'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final write is on the bus this cycle, so the transfer ends here.
        state_d = S_IDLE;
        if (!abort_req) begin
          done_d     = 1'b1;
          done_irq_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and write-pipeline registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= 16'd0;
      remaining_q <= 10'd0;
      dst_off_q   <= 10'd0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      done_irq_q  <= 1'b0;
      vbright_q   <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      remaining_q <= remaining_d;
      dst_off_q   <= dst_off_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      done_irq_q  <= done_irq_d;
      vbright_q   <= bus.vbright;
      wr_en_q     <= rd_fire;
    end
  end

  // Processor-visible configuration registers and registered read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q     <= 16'd0;
      len_q     <= 10'd0;
      memdata_q <= 16'd0;
    end else begin
      if (bus.memwrite && (bus.adr == SRC_REG)) src_q <= bus.writedata;
      if (bus.memwrite && (bus.adr == LEN_REG)) begin
        len_q <= (bus.writedata > MAX_LEN_W) ? MAX_LEN_W[9:0] : bus.writedata[9:0];
      end
      if (bus.adr == SRC_REG)       memdata_q <= src_q;
      else if (bus.adr == LEN_REG)  memdata_q <= {6'd0, len_q};
      else if (bus.adr == CTRL_REG) memdata_q <= {busy_w, (state_q == S_ARMED), done_q,
                                                  overrun_q, 2'b00, remaining_q};
      else                          memdata_q <= 16'd0;
    end
  end

  // Strobes are qualified with reset so a reset takes hold within its own cycle.
  assign bus.memdata  = memdata_q;
  assign bus.bus_req  = rst && ((state_q == S_REQ) || (state_q == S_COPY));
  assign bus.rd_en    = rd_fire;
  assign bus.rd_adr   = src_ptr_q;
  assign bus.wr_en    = rst && wr_en_q;
  assign bus.wr_adr   = wr_en_q ? (SPRITE_BASE + {6'd0, dst_off_q}) : 16'd0;
  assign bus.wr_data  = wr_en_q ? bus.rd_data : 16'd0;
  assign bus.busy     = rst && busy_w;
  assign bus.done_irq = done_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_dma
//  Description : Randomised scoreboard bench for sprite_dma. The stimulus
//                process predicts every read, write, interrupt and sampled
//                register value; a monitor process compares them against the
//                DUT as they appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_dma;

  localparam logic [15:0] SRC_REG     = 16'h4383;
  localparam logic [15:0] LEN_REG     = 16'h4384;
  localparam logic [15:0] CTRL_REG    = 16'h4385;
  localparam logic [15:0] SPRITE_BASE = 16'h4000;
  localparam int          MAX_LEN     = 512;

  // kind: 0 = memdata, 1 = bus_req, 2 = busy (probe queue only)
  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  logic clk;
  logic rst;

  sprite_dma_if bus_if ();

  sprite_dma #(
    .SRC_REG     (SRC_REG),
    .LEN_REG     (LEN_REG),
    .CTRL_REG    (CTRL_REG),
    .SPRITE_BASE (SPRITE_BASE),
    .MAX_LEN     (MAX_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  ev_t         q_rd[$];
  ev_t         q_wr[$];
  ev_t         q_irq[$];
  ev_t         q_pr[$];
  logic [15:0] mem [0:65535];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  bit          fin    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: actual=still running required=finished");
    $fatal(1);
  end

  function automatic ev_t mk(input int c, input int k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (fin) begin
      chk("rd_leftover",    q_rd.size(),  0);
      chk("wr_leftover",    q_wr.size(),  0);
      chk("irq_leftover",   q_irq.size(), 0);
      chk("probe_leftover", q_pr.size(),  0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else begin
      if (bus_if.rd_en) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 32'(bus_if.rd_en), 32'd0);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_adr", 32'(bus_if.rd_adr), 32'(e.a));
        end
      end
      if (bus_if.wr_en) begin
        if (q_wr.size() == 0) chk("wr_unexpected", 32'(bus_if.wr_en), 32'd0);
        else begin
          e = q_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_adr", 32'(bus_if.wr_adr), 32'(e.a));
          chk("wr_data", 32'(bus_if.wr_data), 32'(e.d));
        end
      end
      if (bus_if.done_irq) begin
        if (q_irq.size() == 0) chk("irq_unexpected", 32'(bus_if.done_irq), 32'd0);
        else begin
          e = q_irq.pop_front();
          chk("irq_cycle", cyc, e.cyc);
        end
      end
      for (int i = q_pr.size() - 1; i >= 0; i--) begin
        if (q_pr[i].cyc == cyc) begin
          case (q_pr[i].kind)
            0:       chk("memdata", 32'(bus_if.memdata), 32'(q_pr[i].d));
            1:       chk("bus_req", 32'(bus_if.bus_req), 32'(q_pr[i].d));
            default: chk("busy",    32'(bus_if.busy),    32'(q_pr[i].d));
          endcase
          q_pr.delete(i);
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  // One clock; also serves the main-memory read port (data one cycle later).
  task automatic tick();
    logic        pend;
    logic [15:0] pa;
    @(negedge clk);
    pend = bus_if.rd_en;
    pa   = bus_if.rd_adr;
    @(posedge clk);
    #1;
    bus_if.rd_data = pend ? mem[pa] : 16'($urandom);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
    bus_if.adr       = a;
    bus_if.memwrite  = 1'b1;
    bus_if.writedata = d;
    tick();
    bus_if.memwrite  = 1'b0;
    bus_if.adr       = 16'h0000;
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic [15:0] exp_v);
    q_pr.push_back(mk(cyc + 1, 0, 16'h0, exp_v));
    bus_if.adr = a;
    tick();
    bus_if.adr = 16'h0000;
  endtask

  // mode 0: grant always high; 1: random grant; 2: grant low in copy cycles 3..5
  function automatic bit gen(input int mode, input int idx);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 2) return !(idx >= 3 && idx <= 5);
    return 1'b1;
  endfunction

  task automatic do_copy(input logic [15:0] src, input logic [15:0] len_w, input int mode);
    int n, w, e, t, cnt, idx, last;
    bit b;
    bit g[$];
    n = (len_w > 16'(MAX_LEN)) ? MAX_LEN : int'(len_w);
    wr_reg(SRC_REG, src);
    wr_reg(LEN_REG, len_w);
    rd_reg(LEN_REG, 16'(n));
    bus_if.vbright = 1'b1;
    w = cyc;
    wr_reg(CTRL_REG, 16'h0001);
    if (n == 0) begin
      q_irq.push_back(mk(w + 1, 0, 16'h0, 16'h0));
      for (int i = 1; i <= 3; i++) q_pr.push_back(mk(w + i, 1, 16'h0, 16'h0));
      repeat (3) tick();
      rd_reg(CTRL_REG, 16'h2000);
      rd_reg(CTRL_REG, 16'h0000);
      return;
    end
    rd_reg(CTRL_REG, 16'hC000 | 16'(n));
    repeat ($urandom_range(0, 2)) tick();
    e = cyc;
    bus_if.vbright = 1'b0;
    q_pr.push_back(mk(e + 1, 1, 16'h0, 16'h1));
    // Expected schedule: wait in request until granted, then one read per
    // granted cycle, each written one cycle later, interrupt after the drain.
    g.delete();
    t = e + 1;
    do begin
      b = gen(mode, 0);
      g.push_back(b);
      t++;
    end while (!b);
    cnt  = 0;
    idx  = 1;
    last = t;
    while (cnt < n) begin
      b = gen(mode, idx);
      g.push_back(b);
      if (b) begin
        q_rd.push_back(mk(t, 0, src + 16'(cnt), 16'h0));
        q_wr.push_back(mk(t + 1, 0, SPRITE_BASE + 16'(cnt), mem[src + 16'(cnt)]));
        last = t;
        cnt++;
      end
      t++;
      idx++;
    end
    q_irq.push_back(mk(last + 2, 0, 16'h0, 16'h0));
    q_pr.push_back(mk(last + 1, 1, 16'h0, 16'h0));
    q_pr.push_back(mk(last + 1, 2, 16'h0, 16'h1));
    q_pr.push_back(mk(last + 2, 2, 16'h0, 16'h0));
    tick();
    foreach (g[i]) begin
      bus_if.bus_grant = g[i];
      tick();
    end
    bus_if.bus_grant = 1'($urandom);
    repeat (3) tick();
    bus_if.vbright = 1'b1;
    rd_reg(CTRL_REG, 16'h2000);
    rd_reg(CTRL_REG, 16'h0000);
  endtask

  task automatic do_overrun();
    logic [15:0] src;
    int e;
    src = 16'($urandom);
    wr_reg(SRC_REG, src);
    wr_reg(LEN_REG, 16'd10);
    bus_if.vbright   = 1'b1;
    bus_if.bus_grant = 1'b1;
    wr_reg(CTRL_REG, 16'h0001);
    tick();
    e = cyc;
    bus_if.vbright = 1'b0;
    q_pr.push_back(mk(e + 1, 1, 16'h0, 16'h1));
    for (int i = 0; i < 3; i++) begin
      q_rd.push_back(mk(e + 2 + i, 0, src + 16'(i), 16'h0));
      q_wr.push_back(mk(e + 3 + i, 0, SPRITE_BASE + 16'(i), mem[src + 16'(i)]));
    end
    q_pr.push_back(mk(e + 6, 1, 16'h0, 16'h0));
    q_pr.push_back(mk(e + 6, 2, 16'h0, 16'h0));
    repeat (5) tick();
    bus_if.vbright = 1'b1;
    repeat (3) tick();
    rd_reg(CTRL_REG, 16'h1007);
    rd_reg(CTRL_REG, 16'h0007);
  endtask

  task automatic do_abort_then_wrap();
    int w;
    wr_reg(LEN_REG, 16'd3);
    bus_if.vbright = 1'b1;
    w = cyc;
    wr_reg(CTRL_REG, 16'h0001);
    q_pr.push_back(mk(w + 1, 2, 16'h0, 16'h1));
    q_pr.push_back(mk(w + 2, 2, 16'h0, 16'h0));
    wr_reg(CTRL_REG, 16'h0002);
    tick();
    do_copy(16'hFFFE, 16'd3, 0);
  endtask

  initial begin
    rst              = 1'b0;
    bus_if.adr       = 16'h0000;
    bus_if.memwrite  = 1'b0;
    bus_if.writedata = 16'h0000;
    bus_if.vbright   = 1'b0;
    bus_if.bus_grant = 1'b0;
    bus_if.rd_data   = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[16'h1000 + i] = 16'(i + 1);

    repeat (3) tick();
    q_pr.push_back(mk(cyc, 0, 16'h0, 16'h0));
    q_pr.push_back(mk(cyc, 1, 16'h0, 16'h0));
    q_pr.push_back(mk(cyc, 2, 16'h0, 16'h0));
    tick();
    rst = 1'b1;
    tick();
    rd_reg(SRC_REG,  16'h0000);
    rd_reg(LEN_REG,  16'h0000);
    rd_reg(CTRL_REG, 16'h0000);

    do_copy(16'h1000, 16'd4, 0);
    do_copy(16'($urandom), 16'd0, 0);
    do_copy(16'($urandom), 16'd8, 2);
    do_copy(16'($urandom), 16'd600, 1);
    do_overrun();
    do_abort_then_wrap();
    for (int k = 0; k < 3; k++) begin
      do_copy(16'($urandom), 16'($urandom_range(1, 40)), 1);
    end

    repeat (3) tick();
    fin = 1'b1;
    tick();
  end

endmodule
`default_nettype wire
